// File: rtl/jelly_rtos_sem_requester.sv
// rtl/jelly_rtos_sem_requester.sv - semaphore op-bus requester with per-task wait and tick timeouts
module jelly_rtos_sem_requester #(
    parameter int TSK_NUM      = 8,
    parameter int TSKID_WIDTH  = 3,
    parameter int TSKPRI_WIDTH = 4,
    parameter int SEMID_WIDTH  = 4,
    parameter int TMO_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cke,
    input  logic                    tick,
    input  logic [1:0]              s_cmd_op,
    input  logic [SEMID_WIDTH-1:0]  s_cmd_semid,
    input  logic [TSKID_WIDTH-1:0]  s_cmd_tskid,
    input  logic [TSKPRI_WIDTH-1:0] s_cmd_tskpri,
    input  logic [TMO_WIDTH-1:0]    s_cmd_tmo,
    input  logic                    s_cmd_valid,
    output logic                    s_cmd_ready,
    output logic [SEMID_WIDTH-1:0]  op_semid,
    output logic [TSKID_WIDTH-1:0]  op_tskid,
    output logic [TSKPRI_WIDTH-1:0] op_tskpri,
    output logic                    sig_sem_valid,
    output logic                    pol_sem_valid,
    output logic                    wai_sem_valid,
    output logic                    rel_wai_valid,
    input  logic                    pol_sem_ack,
    input  logic [TSKID_WIDTH-1:0]  wakeup_tskid,
    input  logic                    wakeup_valid,
    output logic [TSKID_WIDTH-1:0]  cmd_done_tskid,
    output logic [1:0]              cmd_done_ercd,
    output logic                    cmd_done_valid,
    output logic [TSKID_WIDTH-1:0]  wup_tskid,
    output logic [1:0]              wup_ercd,
    output logic                    wup_valid
);
    localparam logic [1:0] OP_SIG  = 2'd0;
    localparam logic [1:0] OP_POL  = 2'd1;
    localparam logic [1:0] OP_WAI  = 2'd2;
    localparam logic [1:0] OP_TWAI = 2'd3;

    localparam logic [1:0] ERCD_OK     = 2'd0;
    localparam logic [1:0] ERCD_TMOUT  = 2'd1;
    localparam logic [1:0] ERCD_QUEUED = 2'd2;
    localparam logic [1:0] ERCD_ILUSE  = 2'd3;

    typedef enum logic {TSK_IDLE, TSK_WAITING} tsk_state_e;

    tsk_state_e             state_q [TSK_NUM];
    tsk_state_e             state_d [TSK_NUM];
    logic [SEMID_WIDTH-1:0] semid_q [TSK_NUM];
    logic [SEMID_WIDTH-1:0] semid_d [TSK_NUM];
    logic [TMO_WIDTH-1:0]   cnt_q   [TSK_NUM];
    logic [TMO_WIDTH-1:0]   cnt_d   [TSK_NUM];
    logic [TSK_NUM-1:0]     inf_q, inf_d, exp_q, exp_d;

    logic                    sig_q, pol_q, wai_q, rel_q, iluse_q, twai_q;
    logic [TMO_WIDTH-1:0]    tmo_q;
    logic [SEMID_WIDTH-1:0]  op_semid_q;
    logic [TSKID_WIDTH-1:0]  op_tskid_q;
    logic [TSKPRI_WIDTH-1:0] op_tskpri_q;

    logic                    done_valid_q, wup_valid_q;
    logic [TSKID_WIDTH-1:0]  done_tskid_q, wup_tskid_q;
    logic [1:0]              done_ercd_q, wup_ercd_q;

    logic                    wake_hit, woke_caller, exp_sel_valid, accept, busy;
    logic [TSKID_WIDTH-1:0]  exp_sel;
    logic [TSK_NUM-1:0]      pending;

    // A task being woken this cycle no longer needs its rel_wai, so it is masked from the arbiter.
    always_comb begin
        wake_hit      = wakeup_valid && !rel_q && (state_q[wakeup_tskid] == TSK_WAITING);
        woke_caller   = wakeup_valid && (wakeup_tskid == op_tskid_q);
        pending       = '0;
        exp_sel_valid = 1'b0;
        exp_sel       = '0;
        for (int t = 0; t < TSK_NUM; t++) begin
            pending[t] = (state_q[t] == TSK_WAITING) && exp_q[t]
                         && !(wake_hit && (wakeup_tskid == TSKID_WIDTH'(t)));
        end
        for (int t = TSK_NUM - 1; t >= 0; t--) begin
            if (pending[t]) begin
                exp_sel_valid = 1'b1;
                exp_sel       = TSKID_WIDTH'(t);
            end
        end
    end

    assign s_cmd_ready = !reset && !exp_sel_valid;
    assign accept      = s_cmd_valid && s_cmd_ready && cke;

    always_comb begin
        state_d = state_q;
        semid_d = semid_q;
        cnt_d   = cnt_q;
        inf_d   = inf_q;
        exp_d   = exp_q;
        if (tick) begin
            for (int t = 0; t < TSK_NUM; t++) begin
                if ((state_q[t] == TSK_WAITING) && !inf_q[t] && !exp_q[t] && (cnt_q[t] != '0)) begin
                    cnt_d[t] = cnt_q[t] - TMO_WIDTH'(1);
                    if (cnt_q[t] == TMO_WIDTH'(1)) begin
                        exp_d[t] = 1'b1;
                    end
                end
            end
        end
        if (wai_q && !woke_caller) begin
            state_d[op_tskid_q] = TSK_WAITING;
            semid_d[op_tskid_q] = op_semid_q;
            inf_d[op_tskid_q]   = !twai_q;
            cnt_d[op_tskid_q]   = twai_q ? tmo_q : '0;
            exp_d[op_tskid_q]   = 1'b0;
        end
        if (wake_hit) begin
            state_d[wakeup_tskid] = TSK_IDLE;
            exp_d[wakeup_tskid]   = 1'b0;
        end
        if (exp_sel_valid) begin
            state_d[exp_sel] = TSK_IDLE;
            exp_d[exp_sel]   = 1'b0;
        end
    end

    // A call that would block is checked against the state after this edge, so an in-flight WAI counts.
    assign busy = (state_d[s_cmd_tskid] == TSK_WAITING);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= '{default: TSK_IDLE};
            semid_q      <= '{default: '0};
            cnt_q        <= '{default: '0};
            inf_q        <= '0;
            exp_q        <= '0;
            sig_q        <= 1'b0;
            pol_q        <= 1'b0;
            wai_q        <= 1'b0;
            rel_q        <= 1'b0;
            iluse_q      <= 1'b0;
            twai_q       <= 1'b0;
            tmo_q        <= '0;
            op_semid_q   <= '0;
            op_tskid_q   <= '0;
            op_tskpri_q  <= '0;
            done_valid_q <= 1'b0;
            done_tskid_q <= '0;
            done_ercd_q  <= '0;
            wup_valid_q  <= 1'b0;
            wup_tskid_q  <= '0;
            wup_ercd_q   <= '0;
        end else if (cke) begin
            state_q <= state_d;
            semid_q <= semid_d;
            cnt_q   <= cnt_d;
            inf_q   <= inf_d;
            exp_q   <= exp_d;

            sig_q   <= 1'b0;
            pol_q   <= 1'b0;
            wai_q   <= 1'b0;
            rel_q   <= 1'b0;
            iluse_q <= 1'b0;
            if (exp_sel_valid) begin
                rel_q      <= 1'b1;
                op_tskid_q <= exp_sel;
                op_semid_q <= semid_q[exp_sel];
            end else if (accept) begin
                op_semid_q  <= s_cmd_semid;
                op_tskid_q  <= s_cmd_tskid;
                op_tskpri_q <= s_cmd_tskpri;
                twai_q      <= (s_cmd_op == OP_TWAI);
                tmo_q       <= s_cmd_tmo;
                case (s_cmd_op)
                    OP_SIG: sig_q <= 1'b1;
                    OP_POL: pol_q <= 1'b1;
                    OP_WAI, OP_TWAI: begin
                        if (busy) begin
                            iluse_q <= 1'b1;
                        end else if ((s_cmd_op == OP_TWAI) && (s_cmd_tmo == '0)) begin
                            pol_q <= 1'b1;
                        end else begin
                            wai_q <= 1'b1;
                        end
                    end
                endcase
            end

            done_valid_q <= sig_q || pol_q || wai_q || iluse_q;
            if (sig_q || pol_q || wai_q || iluse_q) begin
                done_tskid_q <= op_tskid_q;
            end
            if (sig_q) begin
                done_ercd_q <= ERCD_OK;
            end else if (pol_q) begin
                done_ercd_q <= pol_sem_ack ? ERCD_OK : ERCD_TMOUT;
            end else if (wai_q) begin
                done_ercd_q <= woke_caller ? ERCD_OK : ERCD_QUEUED;
            end else if (iluse_q) begin
                done_ercd_q <= ERCD_ILUSE;
            end

            wup_valid_q <= rel_q || wake_hit;
            if (rel_q) begin
                wup_tskid_q <= op_tskid_q;
                wup_ercd_q  <= ERCD_TMOUT;
            end else if (wake_hit) begin
                wup_tskid_q <= wakeup_tskid;
                wup_ercd_q  <= ERCD_OK;
            end
        end
    end

    assign op_semid       = op_semid_q;
    assign op_tskid       = op_tskid_q;
    assign op_tskpri      = op_tskpri_q;
    assign sig_sem_valid  = sig_q;
    assign pol_sem_valid  = pol_q;
    assign wai_sem_valid  = wai_q;
    assign rel_wai_valid  = rel_q;
    assign cmd_done_valid = done_valid_q;
    assign cmd_done_tskid = done_tskid_q;
    assign cmd_done_ercd  = done_ercd_q;
    assign wup_valid      = wup_valid_q;
    assign wup_tskid      = wup_tskid_q;
    assign wup_ercd       = wup_ercd_q;
endmodule

// File: tb/tb_jelly_rtos_sem_requester.sv
// tb/tb_jelly_rtos_sem_requester.sv - directed and random bench with semaphore responder and task model
module tb_jelly_rtos_sem_requester;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, cke, tick, s_cmd_valid, s_cmd_ready;
    logic [1:0]  s_cmd_op;
    logic [3:0]  s_cmd_semid, s_cmd_tskpri, op_semid, op_tskpri;
    logic [2:0]  s_cmd_tskid, op_tskid, wakeup_tskid, cmd_done_tskid, wup_tskid;
    logic [15:0] s_cmd_tmo;
    logic        sig_sem_valid, pol_sem_valid, wai_sem_valid, rel_wai_valid;
    logic        pol_sem_ack, wakeup_valid, cmd_done_valid, wup_valid;
    logic [1:0]  cmd_done_ercd, wup_ercd;

    jelly_rtos_sem_requester dut (
        .clk(clk), .reset(reset), .cke(cke), .tick(tick),
        .s_cmd_op(s_cmd_op), .s_cmd_semid(s_cmd_semid), .s_cmd_tskid(s_cmd_tskid),
        .s_cmd_tskpri(s_cmd_tskpri), .s_cmd_tmo(s_cmd_tmo), .s_cmd_valid(s_cmd_valid),
        .s_cmd_ready(s_cmd_ready), .op_semid(op_semid), .op_tskid(op_tskid), .op_tskpri(op_tskpri),
        .sig_sem_valid(sig_sem_valid), .pol_sem_valid(pol_sem_valid), .wai_sem_valid(wai_sem_valid),
        .rel_wai_valid(rel_wai_valid), .pol_sem_ack(pol_sem_ack), .wakeup_tskid(wakeup_tskid),
        .wakeup_valid(wakeup_valid), .cmd_done_tskid(cmd_done_tskid), .cmd_done_ercd(cmd_done_ercd),
        .cmd_done_valid(cmd_done_valid), .wup_tskid(wup_tskid), .wup_ercd(wup_ercd), .wup_valid(wup_valid)
    );

    localparam int K_NONE = 0, K_SIG = 1, K_POL = 2, K_WAI = 3, K_TWAI = 4, K_ILU = 5, K_REL = 6;

    typedef struct {int sem; int tsk;} qent_t;
    qent_t wq[$];
    int    semcnt [16];

    bit mwait [8];
    bit minf  [8];
    bit mexp  [8];
    int msem  [8];
    int mrem  [8];
    int cur_kind, cur_tsk, cur_sem, cur_tmo, cur_pri;
    int e_done_v, e_done_t, e_done_e, e_wup_v, e_wup_t, e_wup_e;
    int errors, checks, obs_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [3:0] pulse_of(input int k);
        case (k)
            K_SIG:         return 4'b1000;
            K_POL:         return 4'b0100;
            K_WAI, K_TWAI: return 4'b0010;
            K_REL:         return 4'b0001;
            default:       return 4'b0000;
        endcase
    endfunction

    task automatic model_reset();
        foreach (mwait[i]) begin mwait[i] = 0; minf[i] = 0; mexp[i] = 0; msem[i] = 0; mrem[i] = 0; end
        cur_kind = K_NONE;
        e_done_v = 0; e_wup_v = 0;
    endtask

    // One clock cycle: check last edge, answer the op bus as the semaphore bank would, advance the model.
    task automatic step(input bit r, input bit ck, input bit tk, input bit v,
                        input int op, input int sem, input int tsk, input int tmo);
        bit wk_v, ack;
        int wk_t, woken, pend, entered, idx, s, pri;
        int n_kind, n_tsk, n_sem, n_tmo, n_pri;
        qent_t e;
        chk("done_valid", cmd_done_valid, e_done_v);
        if (e_done_v != 0) begin
            chk("done_tskid", cmd_done_tskid, e_done_t);
            chk("done_ercd", cmd_done_ercd, e_done_e);
        end
        chk("wup_valid", wup_valid, e_wup_v);
        if (e_wup_v != 0) begin
            chk("wup_tskid", wup_tskid, e_wup_t);
            chk("wup_ercd", wup_ercd, e_wup_e);
        end
        chk("op_pulses", {sig_sem_valid, pol_sem_valid, wai_sem_valid, rel_wai_valid}, pulse_of(cur_kind));
        if (pulse_of(cur_kind) != 4'b0000) begin
            chk("op_tskid", op_tskid, cur_tsk);
            chk("op_semid", op_semid, cur_sem);
            if (cur_kind != K_REL) chk("op_tskpri", op_tskpri, cur_pri);
        end

        wk_v = 0; wk_t = 0; ack = 0; s = int'(op_semid);
        if (r) begin
            wq.delete();
            foreach (semcnt[i]) semcnt[i] = 0;
        end else begin
            if (sig_sem_valid) begin
                idx = -1;
                foreach (wq[i]) if (idx < 0 && wq[i].sem == s) idx = i;
                if (idx >= 0) begin
                    wk_v = 1; wk_t = wq[idx].tsk;
                    if (ck) wq.delete(idx);
                end else if (ck) semcnt[s]++;
            end
            if (pol_sem_valid) begin
                ack = (semcnt[s] > 0);
                if (ck && ack) semcnt[s]--;
            end
            if (wai_sem_valid) begin
                if (semcnt[s] > 0) begin
                    wk_v = 1; wk_t = int'(op_tskid);
                    if (ck) semcnt[s]--;
                end else if (ck) begin
                    e.sem = s; e.tsk = int'(op_tskid);
                    wq.push_back(e);
                end
            end
            if (rel_wai_valid && ck) begin
                idx = -1;
                foreach (wq[i]) if (idx < 0 && wq[i].tsk == int'(op_tskid)) idx = i;
                if (idx >= 0) wq.delete(idx);
            end
        end

        pri = (tsk * 3 + 1) % 16;
        reset = r; cke = ck; tick = tk; s_cmd_valid = v;
        s_cmd_op = 2'(op); s_cmd_semid = 4'(sem); s_cmd_tskid = 3'(tsk);
        s_cmd_tskpri = 4'(pri); s_cmd_tmo = 16'(tmo);
        wakeup_valid = wk_v; wakeup_tskid = 3'(wk_t); pol_sem_ack = ack;
        #1;

        woken = -1;
        if (!r && cur_kind != K_REL && wk_v && mwait[wk_t]) woken = wk_t;
        pend = -1;
        for (int t = 7; t >= 0; t--) if (mwait[t] && mexp[t] && t != woken) pend = t;
        obs_ready = int'(s_cmd_ready);
        chk("cmd_ready", s_cmd_ready, (!r && pend < 0) ? 1 : 0);

        if (r) begin
            model_reset();
        end else if (ck) begin
            e_done_v = 0; e_wup_v = 0; entered = -1;
            if (woken >= 0) begin
                mwait[woken] = 0; mexp[woken] = 0;
                e_wup_v = 1; e_wup_t = woken; e_wup_e = 0;
            end
            case (cur_kind)
                K_SIG: begin e_done_v = 1; e_done_t = cur_tsk; e_done_e = 0; end
                K_POL: begin e_done_v = 1; e_done_t = cur_tsk; e_done_e = ack ? 0 : 1; end
                K_WAI, K_TWAI: begin
                    e_done_v = 1; e_done_t = cur_tsk;
                    if (wk_v && wk_t == cur_tsk) e_done_e = 0;
                    else begin
                        e_done_e = 2; entered = cur_tsk;
                        mwait[cur_tsk] = 1; msem[cur_tsk] = cur_sem; mexp[cur_tsk] = 0;
                        minf[cur_tsk] = (cur_kind == K_WAI); mrem[cur_tsk] = cur_tmo;
                    end
                end
                K_ILU: begin e_done_v = 1; e_done_t = cur_tsk; e_done_e = 3; end
                K_REL: begin e_wup_v = 1; e_wup_t = cur_tsk; e_wup_e = 1; end
                default: ;
            endcase
            n_kind = K_NONE; n_tsk = 0; n_sem = 0; n_tmo = 0; n_pri = 0;
            if (pend >= 0) begin
                n_kind = K_REL; n_tsk = pend; n_sem = msem[pend];
                mwait[pend] = 0; mexp[pend] = 0;
            end else if (v) begin
                n_tsk = tsk; n_sem = sem; n_tmo = tmo; n_pri = pri;
                if (op == 0) n_kind = K_SIG;
                else if (op == 1) n_kind = K_POL;
                else if (mwait[tsk]) n_kind = K_ILU;
                else if (op == 3 && tmo == 0) n_kind = K_POL;
                else n_kind = (op == 2) ? K_WAI : K_TWAI;
            end
            if (tk) begin
                for (int t = 0; t < 8; t++) begin
                    if (mwait[t] && !minf[t] && !mexp[t] && t != entered) begin
                        mrem[t]--;
                        if (mrem[t] == 0) mexp[t] = 1;
                    end
                end
            end
            cur_kind = n_kind; cur_tsk = n_tsk; cur_sem = n_sem; cur_tmo = n_tmo; cur_pri = n_pri;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cyc(input bit tk);
        step(0, 1, tk, 0, 0, 0, 0, 0);
    endtask

    task automatic cmd(input int op, input int sem, input int tsk, input int tmo);
        step(0, 1, 0, 1, op, sem, tsk, tmo);
    endtask

    initial begin
        errors = 0; checks = 0;
        reset = 1; cke = 1; tick = 0; s_cmd_valid = 0; s_cmd_op = 0; s_cmd_semid = 0;
        s_cmd_tskid = 0; s_cmd_tskpri = 0; s_cmd_tmo = 0;
        pol_sem_ack = 0; wakeup_valid = 0; wakeup_tskid = 0;
        foreach (semcnt[i]) semcnt[i] = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_op_tskid", op_tskid, 0);
        step(1, 1, 0, 1, 0, 0, 0, 0);
        chk("rst_ready", obs_ready, 0);

        // 1: WAI with a free count completes at once
        semcnt[1] = 1;
        cmd(2, 1, 2, 0);
        chk("t1_wai_pulse", wai_sem_valid, 1);
        cyc(0);
        chk("t1_done", {cmd_done_valid, cmd_done_tskid, cmd_done_ercd}, {1'b1, 3'd2, 2'd0});

        // 2: queued waiter released by a later SIG
        cmd(2, 1, 3, 0);
        cyc(0);
        chk("t2_queued", {cmd_done_valid, cmd_done_tskid, cmd_done_ercd}, {1'b1, 3'd3, 2'd2});
        cmd(0, 1, 5, 0);
        cyc(0);
        chk("t2_sig_done", {cmd_done_valid, cmd_done_tskid, cmd_done_ercd}, {1'b1, 3'd5, 2'd0});
        chk("t2_wup", {wup_valid, wup_tskid, wup_ercd}, {1'b1, 3'd3, 2'd0});

        // 3: TWAI timeout
        cmd(3, 2, 4, 3);
        cyc(0);
        repeat (3) cyc(1);
        cmd(0, 5, 0, 0);
        chk("t3_ready_stall", obs_ready, 0);
        chk("t3_rel", {rel_wai_valid, op_tskid, op_semid}, {1'b1, 3'd4, 4'd2});
        cyc(0);
        chk("t3_wup", {wup_valid, wup_tskid, wup_ercd}, {1'b1, 3'd4, 2'd1});

        // 4: polls
        cmd(1, 3, 1, 0);
        cyc(0);
        chk("t4_pol_fail", {cmd_done_valid, cmd_done_ercd}, {1'b1, 2'd1});
        semcnt[3] = 2;
        cmd(3, 3, 1, 0);
        chk("t4_twai0_pol", pol_sem_valid, 1);
        cyc(0);
        chk("t4_twai0_ok", {cmd_done_valid, cmd_done_ercd}, {1'b1, 2'd0});

        // 5: two expiries on one tick drain lowest id first
        cmd(3, 4, 1, 2);
        cmd(3, 4, 6, 1);
        cyc(1);
        cyc(1);
        cmd(0, 5, 0, 0);
        chk("t5_rel_t1", {rel_wai_valid, op_tskid}, {1'b1, 3'd1});
        cmd(0, 5, 0, 0);
        chk("t5_rel_t6", {rel_wai_valid, op_tskid}, {1'b1, 3'd6});
        chk("t5_wup_t1", {wup_valid, wup_tskid, wup_ercd}, {1'b1, 3'd1, 2'd1});
        cmd(0, 5, 0, 0);
        chk("t5_wup_t6", {wup_valid, wup_tskid, wup_ercd}, {1'b1, 3'd6, 2'd1});
        chk("t5_cmd_resumes", sig_sem_valid, 1);

        // 6: double WAI, then reset discards the wait
        cmd(2, 6, 3, 0);
        cyc(0);
        cmd(2, 6, 3, 0);
        chk("t6_no_pulse", {sig_sem_valid, pol_sem_valid, wai_sem_valid, rel_wai_valid}, 4'b0000);
        cyc(0);
        chk("t6_iluse", {cmd_done_valid, cmd_done_tskid, cmd_done_ercd}, {1'b1, 3'd3, 2'd3});
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        cmd(0, 6, 0, 0);
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            chk("t6_no_wup", wup_valid, 0);
        end

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) != 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 1) == 1), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 7), $urandom_range(0, 5));
        end
        repeat (3) cyc(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
